// File: rtl/punc_debug_dumper.sv
// rtl/punc_debug_dumper.sv - dumps PC, register file and a memory range over a valid/ready stream
// Each word drives its debug address, waits for it to settle, then presents the sampled data.
module punc_debug_dumper #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] mem_base,
    input  logic [15:0] mem_count,
    output logic [15:0] mem_debug_addr,
    output logic [2:0]  rf_debug_addr,
    input  logic [15:0] mem_debug_data,
    input  logic [15:0] rf_debug_data,
    input  logic [15:0] pc_debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_tag,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam logic [1:0] PH_PC  = 2'd0;
    localparam logic [1:0] PH_RF  = 2'd1;
    localparam logic [1:0] PH_MEM = 2'd2;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  phase;
    logic [2:0]  rf_idx;
    logic [15:0] base_q;
    logic [15:0] count_q;
    logic [15:0] remaining;
    logic [3:0]  settle_cnt;
    logic        launch;
    logic        handshake;
    logic        settle_done;
    logic        final_word;
    logic [15:0] sel_data;

    assign handshake   = out_valid && out_ready;
    assign settle_done = (state == SETTLE) && !launch && (settle_cnt == 4'd1);

    always_comb begin
        final_word = 1'b0;
        sel_data   = pc_debug_data;
        case (phase)
            PH_RF: begin
                final_word = (rf_idx == 3'd7) && (count_q == 16'd0);
                sel_data   = rf_debug_data;
            end
            PH_MEM: begin
                final_word = (remaining == 16'd1);
                sel_data   = mem_debug_data;
            end
            default: begin
                final_word = 1'b0;
                sel_data   = pc_debug_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (abort)            state_nxt = IDLE;
                else if (settle_done) state_nxt = SEND;
            end
            SEND: begin
                if (abort)          state_nxt = IDLE;
                else if (handshake) state_nxt = out_last ? IDLE : SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // The first SETTLE cycle launches the registered address; the countdown then
    // measures how long the processor has seen that address before sampling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase          <= PH_PC;
            rf_idx         <= '0;
            base_q         <= '0;
            count_q        <= '0;
            remaining      <= '0;
            settle_cnt     <= '0;
            launch         <= 1'b0;
            mem_debug_addr <= '0;
            rf_debug_addr  <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_tag        <= '0;
            out_last       <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q         <= mem_base;
                        count_q        <= mem_count;
                        remaining      <= mem_count;
                        phase          <= PH_PC;
                        rf_idx         <= '0;
                        mem_debug_addr <= mem_base;
                        rf_debug_addr  <= '0;
                        settle_cnt     <= SETTLE_LOAD;
                        launch         <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        rf_debug_addr <= '0;
                        settle_cnt    <= '0;
                        launch        <= 1'b0;
                    end else if (launch) begin
                        launch <= 1'b0;
                    end else if (settle_cnt == 4'd1) begin
                        out_valid  <= 1'b1;
                        out_data   <= sel_data;
                        out_tag    <= phase;
                        out_last   <= final_word;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid     <= 1'b0;
                        rf_debug_addr <= '0;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done          <= 1'b1;
                            rf_debug_addr <= '0;
                        end else begin
                            settle_cnt <= SETTLE_LOAD;
                            launch     <= 1'b1;
                            case (phase)
                                PH_PC: begin
                                    phase         <= PH_RF;
                                    rf_idx        <= '0;
                                    rf_debug_addr <= '0;
                                end
                                PH_RF: begin
                                    if (rf_idx == 3'd7) begin
                                        phase          <= PH_MEM;
                                        mem_debug_addr <= base_q;
                                        rf_debug_addr  <= 3'd7;
                                        remaining      <= count_q;
                                    end else begin
                                        rf_idx        <= rf_idx + 3'd1;
                                        rf_debug_addr <= rf_idx + 3'd1;
                                    end
                                end
                                default: begin
                                    mem_debug_addr <= mem_debug_addr + 16'd1;
                                    remaining      <= remaining - 16'd1;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/punc_debug_dumper.md
PUNC_DEBUG_DUMPER -- requirements
Module: punc_debug_dumper

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 1, number of cycles (legal range 1..15) between driving a debug address and sampling its data.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a dump; sampled only while busy=0.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of a dump in progress.
REQ-006 The block SHALL have port mem_base, input, 16 bits: first memory address to dump; latched on accepted start.
REQ-007 The block SHALL have port mem_count, input, 16 bits: number of memory words to dump (0..65535); latched on accepted start.
REQ-008 The block SHALL have port mem_debug_addr, output, 16 bits: memory debug address driven to the processor.
REQ-009 The block SHALL have port rf_debug_addr, output, 3 bits: register-file debug address driven to the processor.
REQ-010 The block SHALL have ports mem_debug_data, rf_debug_data and pc_debug_data, each an input of 16 bits: read data from the processor debug port.
REQ-011 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_data (output, 16 bits), out_tag (output, 2 bits: 0=PC, 1=RF, 2=MEM) and out_last (output, 1 bit), forming the dump stream.
REQ-012 The block SHALL have port busy, output, 1 bit: high from accepted start until return to IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final word completes its handshake.

Function
REQ-014 The block SHALL implement the states IDLE, SETTLE and SEND.
REQ-015 The dump order SHALL be: PC (1 word), then R0..R7 (8 words), then mem_count words from mem_base upward, i.e. 9+mem_count words in total.
REQ-016 In IDLE with start=1, the block SHALL latch mem_base and mem_count, set phase=PC, load the settle counter with SETTLE_CYCLES, assert busy and enter SETTLE.
REQ-017 A start arriving while busy=1 SHALL be ignored.
REQ-018 In SETTLE, the block SHALL hold the addresses stable and decrement the counter each cycle.
REQ-019 On the SETTLE cycle with counter=1, the block SHALL register the phase-selected data (pc/rf/mem) into out_data, set out_tag and out_last, and enter SEND with out_valid=1.
REQ-020 Word timing: out_valid SHALL first rise SETTLE_CYCLES+1 edges after the edge sampling start, and SETTLE_CYCLES+1 edges after each handshake edge.
REQ-021 In SEND, while out_valid=1 and out_ready=0, out_data, out_tag and out_last SHALL remain stable.
REQ-022 A handshake SHALL be the condition out_valid and out_ready high at a rising edge; at that edge out_valid SHALL drop.
REQ-023 Advance after handshake: PC -> RF index 0.
REQ-024 Advance after handshake: RF index<7 -> index+1.
REQ-025 Advance after handshake: RF index 7 -> MEM phase at mem_base if mem_count!=0, else finish.
REQ-026 Advance after handshake: MEM with remaining>1 -> address+1, wrapping 16'hFFFF to 16'h0000, and remaining-1; with remaining=1, finish.
REQ-027 On finish, the block SHALL enter IDLE and pulse done for exactly one cycle (the cycle after the final handshake edge), with busy low in that same cycle.
REQ-028 out_last SHALL be 1 only on the final word: R7 when mem_count=0, else the last MEM word.
REQ-029 mem_debug_addr SHALL equal the latched mem_base during the PC and RF phases, the current address during the MEM phase, and hold its last value in IDLE.
REQ-030 rf_debug_addr SHALL equal the RF index during the RF phase, 7 during the MEM phase, and 0 otherwise.
REQ-031 abort=1 in SETTLE or SEND SHALL force IDLE at the next edge, with out_valid=0, busy=0, no done pulse, and any pending word discarded.
REQ-032 abort=1 in IDLE SHALL have no effect.
REQ-033 If abort and start are both 1 in IDLE, start SHALL win.
REQ-034 If abort and a handshake coincide, abort SHALL win; the word counts as transferred, but no done pulse is generated.

Reset
REQ-035 rst=0 SHALL asynchronously force IDLE and drive every output to 0 (mem_debug_addr, rf_debug_addr, out_valid, out_data, out_tag, out_last, busy, done), and clear all counters.
REQ-036 Reset asserted mid-dump SHALL abandon the dump; after release the block SHALL wait for a new start.
REQ-037 Release of rst SHALL take effect only on a clock edge; no start is accepted on the same edge as release.

Verification
REQ-038 Scenario: SETTLE_CYCLES=1, pc=16'h3005, R0..R7=16'h0010..16'h0017, mem_count=0, out_ready tied 1 -> 9 words with tags 0,1x8 and data 3005,0010..0017; out_last on 0017; done one cycle later.
REQ-039 Scenario: mem_base=16'hFFFE, mem_count=3, memory FFFE=AAAA, FFFF=BBBB, 0000=CCCC -> MEM words AAAA, BBBB, CCCC with mem_debug_addr wrapping to 0000; out_last on CCCC.
REQ-040 Scenario: out_ready held 0 for 5 cycles on the R3 word -> out_valid stays 1 and out_data stays stable; R4 appears SETTLE_CYCLES+1 edges after the handshake.
REQ-041 Scenario: abort asserted during the 2nd MEM word -> out_valid=0 and busy=0 next cycle, no done; a fresh start then restarts with the PC word.
REQ-042 Scenario: start re-pulsed while busy, and rst pulled low mid-RF phase -> the repeated start is ignored; on reset all outputs read 0 immediately without a clock edge.
REQ-043 Scenario: SETTLE_CYCLES=3 -> 4 edges from start to first out_valid; data is sampled only after the address has been stable for 3 cycles.
